// File: rtl/ualink_pkg.sv
// Shared definitions for the UALink packet generator: frame header words,
// controller states and the 16-bit LFSR step used for port/opcode selection.
package ualink_pkg;

  localparam logic [63:0] HDR0_WR = 64'hEFBEFECAFECAFECA;
  localparam logic [63:0] HDR0_RD = 64'hEFBEFECAFECAFFCA;
  localparam logic [63:0] HDR1_WR = 64'h00000008EFBEEFBE;
  localparam logic [63:0] HDR1_RD = 64'h00000008EFBEEEBE;

  // Fibonacci taps 16,14,13,11 expressed as a mask over bits [15:0].
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    PAYLOAD,
    GAP,
    NEXT
  } state_e;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/ualink_lfsr16.sv
// 16-bit Fibonacci LFSR with seed load and step enable; o_next is the value
// the register takes on a load or step, so callers can act on it in the same cycle.
module ualink_lfsr16
  import ualink_pkg::*;
#(
  parameter logic [15:0] LFSR_RESET = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic [15:0] i_seed,
  input  logic        i_step,
  output logic [15:0] o_next
);

  logic [15:0] r_lfsr;

  // A load is always followed by one step, hence the seed also passes through lfsr_step.
  assign o_next = lfsr_step(i_load ? i_seed : r_lfsr);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= LFSR_RESET;
    end else if (i_load || i_step) begin
      r_lfsr <= o_next;
    end
  end

endmodule

// File: rtl/ualink_pkt_gen.sv
// AXI-Stream UALink frame generator driving NUM_PORTS streams, one LFSR-chosen port per packet.
// Define UALINK_PKTGEN_READ_EN to let lfsr[15] select read headers; otherwise all packets are writes.
module ualink_pkt_gen
  import ualink_pkg::*;
#(
  parameter int          NUM_PORTS   = 5,
  parameter int          DATA_WIDTH  = 64,
  parameter int          TUSER_WIDTH = 128,
  parameter logic [15:0] LFSR_RESET  = 16'hACE1
) (
  input  logic                              axi_aclk,
  input  logic                              axi_resetn,
  input  logic                              start,
  input  logic [7:0]                        cfg_payload_len,
  input  logic [7:0]                        cfg_gap,
  input  logic [15:0]                       cfg_seed,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [NUM_PORTS*DATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic [NUM_PORTS*TUSER_WIDTH-1:0]  m_axis_tuser,
  output logic [NUM_PORTS-1:0]              m_axis_tvalid,
  input  logic [NUM_PORTS-1:0]              m_axis_tready,
  output logic [NUM_PORTS-1:0]              m_axis_tlast,
  output logic                              busy,
  output logic [31:0]                       pkt_count
);

  localparam int SW = DATA_WIDTH / 8;

  state_e      r_state, w_state_nxt;
  logic [7:0]  r_len, w_len_nxt, r_gap, w_gap_nxt;
  logic [7:0]  r_gap_cnt, w_gap_cnt_nxt, r_cnt, w_cnt_nxt;
  logic [2:0]  r_port, w_port_nxt, w_pick_port;
  logic        r_read, w_read_nxt, w_pick_read;
  logic [31:0] r_pkt_count, w_pkt_count_nxt;
  logic        w_load, w_step, w_latch, w_beat;
  logic [15:0] w_seed, w_lfsr_next;
  logic        w_unused_lfsr;

  logic [NUM_PORTS*DATA_WIDTH-1:0]   r_tdata, w_tdata_nxt;
  logic [NUM_PORTS*SW-1:0]           r_tstrb, w_tstrb_nxt;
  logic [NUM_PORTS*TUSER_WIDTH-1:0]  r_tuser, w_tuser_nxt;
  logic [NUM_PORTS-1:0]              r_tvalid, w_tvalid_nxt, r_tlast, w_tlast_nxt;
  logic                              r_busy;
  logic [DATA_WIDTH-1:0]             w_word;

  ualink_lfsr16 #(.LFSR_RESET(LFSR_RESET)) u_lfsr (
    .clk    (axi_aclk),
    .rst_n  (axi_resetn),
    .i_load (w_load),
    .i_seed (w_seed),
    .i_step (w_step),
    .o_next (w_lfsr_next)
  );

  assign w_seed        = (cfg_seed == 16'h0000) ? LFSR_RESET : cfg_seed;
  assign w_pick_port   = 3'(w_lfsr_next[7:0] % 8'(NUM_PORTS));
  assign w_unused_lfsr = ^w_lfsr_next[15:8];
`ifdef UALINK_PKTGEN_READ_EN
  assign w_pick_read   = w_lfsr_next[15];
`else
  assign w_pick_read   = 1'b0;
`endif

  // Only the active port can be valid, so any valid&ready bit is the beat.
  assign w_beat = |(r_tvalid & m_axis_tready);

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_len_nxt       = r_len;
    w_gap_nxt       = r_gap;
    w_gap_cnt_nxt   = r_gap_cnt;
    w_cnt_nxt       = r_cnt;
    w_port_nxt      = r_port;
    w_read_nxt      = r_read;
    w_pkt_count_nxt = r_pkt_count;
    w_load          = 1'b0;
    w_step          = 1'b0;
    w_latch         = 1'b0;
    case (r_state)
      IDLE: if (start) begin
        w_load      = 1'b1;
        w_latch     = 1'b1;
        w_state_nxt = HDR0;
      end
      HDR0: if (w_beat) w_state_nxt = HDR1;
      HDR1: if (w_beat) begin
        w_state_nxt = PAYLOAD;
        w_cnt_nxt   = 8'd0;
      end
      PAYLOAD: if (w_beat) begin
        if (r_cnt == r_len) begin
          w_pkt_count_nxt = r_pkt_count + 32'd1;
          w_gap_cnt_nxt   = r_gap;
          w_state_nxt     = (r_gap == 8'd0) ? NEXT : GAP;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      GAP: begin
        if (r_gap_cnt == 8'd1) w_state_nxt = NEXT;
        else                   w_gap_cnt_nxt = r_gap_cnt - 8'd1;
      end
      NEXT: begin
        if (start) begin
          w_step      = 1'b1;
          w_latch     = 1'b1;
          w_state_nxt = HDR0;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_latch) begin
      w_len_nxt  = cfg_payload_len;
      w_gap_nxt  = cfg_gap;
      w_port_nxt = w_pick_port;
      w_read_nxt = w_pick_read;
    end
  end

  // Output vectors are computed from the next state and registered, so ports never see input glitches.
  always_comb begin
    w_tvalid_nxt = '0;
    w_tlast_nxt  = '0;
    w_tdata_nxt  = '0;
    w_tstrb_nxt  = '0;
    w_tuser_nxt  = '0;
    case (w_state_nxt)
      HDR0:    w_word = DATA_WIDTH'(w_read_nxt ? HDR0_RD : HDR0_WR);
      HDR1:    w_word = DATA_WIDTH'(w_read_nxt ? HDR1_RD : HDR1_WR);
      PAYLOAD: w_word = {SW{w_cnt_nxt}};
      default: w_word = '0;
    endcase
    if (w_state_nxt inside {HDR0, HDR1, PAYLOAD}) begin
      w_tvalid_nxt[w_port_nxt] = 1'b1;
      w_tlast_nxt[w_port_nxt]  = (w_state_nxt == PAYLOAD) && (w_cnt_nxt == w_len_nxt);
      w_tdata_nxt[w_port_nxt*DATA_WIDTH +: DATA_WIDTH]   = w_word;
      w_tstrb_nxt[w_port_nxt*SW +: SW]                   = '1;
      w_tuser_nxt[w_port_nxt*TUSER_WIDTH +: TUSER_WIDTH] = TUSER_WIDTH'({5'b00000, w_port_nxt});
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      r_state     <= IDLE;
      r_len       <= '0;
      r_gap       <= '0;
      r_gap_cnt   <= '0;
      r_cnt       <= '0;
      r_port      <= '0;
      r_read      <= 1'b0;
      r_pkt_count <= '0;
      r_tvalid    <= '0;
      r_tlast     <= '0;
      r_tdata     <= '0;
      r_tstrb     <= '0;
      r_tuser     <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_len       <= w_len_nxt;
      r_gap       <= w_gap_nxt;
      r_gap_cnt   <= w_gap_cnt_nxt;
      r_cnt       <= w_cnt_nxt;
      r_port      <= w_port_nxt;
      r_read      <= w_read_nxt;
      r_pkt_count <= w_pkt_count_nxt;
      r_tvalid    <= w_tvalid_nxt;
      r_tlast     <= w_tlast_nxt;
      r_tdata     <= w_tdata_nxt;
      r_tstrb     <= w_tstrb_nxt;
      r_tuser     <= w_tuser_nxt;
      r_busy      <= (w_state_nxt != IDLE);
    end
  end

  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tstrb  = r_tstrb;
  assign m_axis_tuser  = r_tuser;
  assign busy          = r_busy;
  assign pkt_count     = r_pkt_count;

endmodule
